// File: rtl/ip_port_master.sv
// Requester front-end for one system_agent IP port: buffers core requests, allocates
// transaction tags, presents requests until granted and returns tagged completions.
module ip_port_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic        core_req_we,
    input  logic [15:0] core_req_addr,
    input  logic [31:0] core_req_wdata,
    output logic        core_rsp_valid,
    output logic [3:0]  core_rsp_tag,
    output logic [31:0] core_rsp_rdata,
    output logic [5:0]  ip_req_trans,
    output logic [15:0] ip_addr,
    output logic [31:0] ip_wdat,
    input  logic        ip_gnt,
    input  logic        ip_done,
    input  logic [3:0]  ip_trans_id,
    input  logic [31:0] ip_rdat,
    output logic        err_unexp
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 49;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [15:0]   TAG_MASK = (MAX_OUT >= 16) ? 16'hFFFF : ((16'd1 << MAX_OUT) - 16'd1);
    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_ISSUE  = 1'b1;

    function automatic logic [3:0] lowest_tag(input logic [15:0] v);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                t = 4'(i);
            end else begin
                t = t;
            end
        end
        return t;
    endfunction

    logic [0:0]    state_q, state_d;
    logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [EW-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic [5:0]    trans_q, trans_d;
    logic [15:0]   addr_q, addr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [15:0]   outstanding_q, outstanding_d;
    logic [15:0]   we_tag_q, we_tag_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [3:0]    rsp_tag_q, rsp_tag_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          err_q, err_d;

    logic          push_s, pop_s, done_ok_s;
    logic [EW-1:0] head_s, next_s;
    logic [15:0]   free_s, free_next_s, gnt_mask_s, done_mask_s;

    // Request FIFO: write on accepted core request, read when the agent grants.
    always_comb begin
        push_s     = core_req_valid & ready_q;
        pop_s      = (state_q == S_ISSUE) & ip_gnt;
        fifo_mem_d = fifo_mem_q;
        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = {core_req_we, core_req_addr, core_req_wdata};
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_FULL);
        head_s  = fifo_mem_q[rd_ptr_q];
        next_s  = fifo_mem_q[rd_ptr_q + PTR_ONE];
    end

    // Tag bookkeeping and completion return; a tag freed here is only visible next cycle.
    always_comb begin
        done_ok_s     = ip_done & outstanding_q[ip_trans_id];
        gnt_mask_s    = pop_s ? (16'd1 << trans_q[3:0]) : 16'd0;
        done_mask_s   = done_ok_s ? (16'd1 << ip_trans_id) : 16'd0;
        free_s        = ~outstanding_q & TAG_MASK;
        free_next_s   = free_s & ~gnt_mask_s;
        outstanding_d = (outstanding_q | gnt_mask_s) & ~done_mask_s;
        if (pop_s) begin
            we_tag_d = trans_q[4] ? (we_tag_q | gnt_mask_s) : (we_tag_q & ~gnt_mask_s);
        end else begin
            we_tag_d = we_tag_q;
        end
        rsp_valid_d = done_ok_s;
        rsp_tag_d   = done_ok_s ? ip_trans_id : 4'd0;
        rsp_rdata_d = (done_ok_s && !we_tag_q[ip_trans_id]) ? ip_rdat : 32'd0;
        err_d       = err_q | (ip_done & ~outstanding_q[ip_trans_id]);
    end

    // Issue FSM: latch head entry plus lowest free tag, hold until granted.
    always_comb begin
        state_d = state_q;
        trans_d = trans_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != CNT_ZERO) && (|free_s)) begin
                    state_d = S_ISSUE;
                    trans_d = {1'b1, head_s[48], lowest_tag(free_s)};
                    addr_d  = head_s[47:32];
                    wdat_d  = head_s[31:0];
                end else begin
                    state_d = S_IDLE;
                    trans_d = 6'd0;
                    addr_d  = 16'd0;
                    wdat_d  = 32'd0;
                end
            end
            S_ISSUE: begin
                if (ip_gnt) begin
                    if ((count_q >= CNT_TWO) && (|free_next_s)) begin
                        state_d = S_ISSUE;
                        trans_d = {1'b1, next_s[48], lowest_tag(free_next_s)};
                        addr_d  = next_s[47:32];
                        wdat_d  = next_s[31:0];
                    end else begin
                        state_d = S_IDLE;
                        trans_d = 6'd0;
                        addr_d  = 16'd0;
                        wdat_d  = 32'd0;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
                trans_d = 6'd0;
                addr_d  = 16'd0;
                wdat_d  = 32'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= {EW{1'b0}};
            end
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            count_q       <= CNT_ZERO;
            ready_q       <= 1'b1;
            trans_q       <= 6'd0;
            addr_q        <= 16'd0;
            wdat_q        <= 32'd0;
            outstanding_q <= 16'd0;
            we_tag_q      <= 16'd0;
            rsp_valid_q   <= 1'b0;
            rsp_tag_q     <= 4'd0;
            rsp_rdata_q   <= 32'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifo_mem_q    <= fifo_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            trans_q       <= trans_d;
            addr_q        <= addr_d;
            wdat_q        <= wdat_d;
            outstanding_q <= outstanding_d;
            we_tag_q      <= we_tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_rdata_q   <= rsp_rdata_d;
            err_q         <= err_d;
        end
    end

    assign core_req_ready = ready_q;
    assign ip_req_trans   = trans_q;
    assign ip_addr        = addr_q;
    assign ip_wdat        = wdat_q;
    assign core_rsp_valid = rsp_valid_q;
    assign core_rsp_tag   = rsp_tag_q;
    assign core_rsp_rdata = rsp_rdata_q;
    assign err_unexp      = err_q;

endmodule

// File: tb/tb_ip_port_master.sv
// Scoreboard bench for ip_port_master: expected grants and completions are queued as
// stimulus is driven and compared when the DUT presents them.
module tb_ip_port_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_valid, core_req_ready, core_req_we;
    logic [15:0] core_req_addr;
    logic [31:0] core_req_wdata;
    logic        core_rsp_valid;
    logic [3:0]  core_rsp_tag;
    logic [31:0] core_rsp_rdata;
    logic [5:0]  ip_req_trans;
    logic [15:0] ip_addr;
    logic [31:0] ip_wdat;
    logic        ip_gnt, ip_done;
    logic [3:0]  ip_trans_id;
    logic [31:0] ip_rdat;
    logic        err_unexp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_gnt = 0;
    logic [48:0] req_q [$];
    logic [35:0] rsp_q [$];
    int          gnt_cyc [$];
    logic [15:0] m_out = 16'd0;
    logic [15:0] m_we  = 16'd0;
    logic [3:0]  last_gnt_tag = 4'd0;

    ip_port_master #(.FIFO_DEPTH(4), .MAX_OUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_tag(core_rsp_tag), .core_rsp_rdata(core_rsp_rdata),
        .ip_req_trans(ip_req_trans), .ip_addr(ip_addr), .ip_wdat(ip_wdat),
        .ip_gnt(ip_gnt), .ip_done(ip_done), .ip_trans_id(ip_trans_id), .ip_rdat(ip_rdat),
        .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_free_tag(input logic [15:0] busy);
        for (int i = 0; i < 8; i++) begin
            if (!busy[i]) return 4'(i);
        end
        return 4'hF;
    endfunction

    // Monitor at the falling edge: inputs and outputs are stable mid-cycle.
    initial forever begin
        logic [35:0] er;
        logic [48:0] eq;
        @(negedge clk);
        if (rst_n) begin
            if (core_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexp", 64'd1, 64'd0);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_tag", 64'(core_rsp_tag), 64'(er[35:32]));
                    chk("rsp_rdata", 64'(core_rsp_rdata), 64'(er[31:0]));
                end
            end
            if (ip_req_trans[5] && ip_gnt) begin
                chk("gnt_tag", 64'(ip_req_trans[3:0]), 64'(exp_free_tag(m_out)));
                if (req_q.size() == 0) begin
                    chk("req_unexp", 64'd1, 64'd0);
                end else begin
                    eq = req_q.pop_front();
                    chk("gnt_we", 64'(ip_req_trans[4]), 64'(eq[48]));
                    chk("gnt_addr", 64'(ip_addr), 64'(eq[47:32]));
                    chk("gnt_wdat", 64'(ip_wdat), 64'(eq[31:0]));
                end
                m_out[ip_req_trans[3:0]] = 1'b1;
                m_we[ip_req_trans[3:0]]  = ip_req_trans[4];
                last_gnt_tag = ip_req_trans[3:0];
                n_gnt++;
                gnt_cyc.push_back(cyc);
            end
            if (ip_done && m_out[ip_trans_id]) begin
                rsp_q.push_back({ip_trans_id, m_we[ip_trans_id] ? 32'd0 : ip_rdat});
                m_out[ip_trans_id] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        core_req_valid = 1'b0; core_req_we = 1'b0; core_req_addr = 16'd0; core_req_wdata = 32'd0;
        ip_gnt = 1'b0; ip_done = 1'b0; ip_trans_id = 4'd0; ip_rdat = 32'd0;
        repeat (2) tick();
        chk("rst_trans", 64'(ip_req_trans), 64'd0);
        chk("rst_rsp_v", 64'(core_rsp_valid), 64'd0);
        chk("rst_ready", 64'(core_req_ready), 64'd1);
        chk("rst_err", 64'(err_unexp), 64'd0);
        req_q.delete(); rsp_q.delete(); gnt_cyc.delete();
        m_out = 16'd0; m_we = 16'd0; n_gnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic push_req(input logic we, input logic [15:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        core_req_valid = 1'b1; core_req_we = we; core_req_addr = a; core_req_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (core_req_ready) ok = 1'b1;
            tick();
        end
        if (ok) req_q.push_back({we, a, d});
        else chk("push_timeout", 64'd0, 64'd1);
        core_req_valid = 1'b0;
    endtask

    task automatic wait_gnts(input int n);
        for (int i = 0; i < 100 && n_gnt < n; i++) tick();
        if (n_gnt < n) chk("gnt_timeout", 64'(n_gnt), 64'(n));
    endtask

    task automatic wait_issue();
        for (int i = 0; i < 20 && !ip_req_trans[5]; i++) tick();
    endtask

    task automatic complete(input logic [3:0] id, input logic [31:0] rd);
        ip_done = 1'b1; ip_trans_id = id; ip_rdat = rd;
        tick();
        ip_done = 1'b0;
    endtask

    initial begin
        do_reset();

        // single read with delayed grant
        push_req(1'b0, 16'h0010, 32'd0);
        wait_issue();
        chk("rd_trans", 64'(ip_req_trans), 64'(6'b100000));
        chk("rd_addr", 64'(ip_addr), 64'h0010);
        tick();
        chk("rd_hold", 64'(ip_req_trans), 64'(6'b100000));
        tick();
        ip_gnt = 1'b1;
        tick();
        ip_gnt = 1'b0;
        chk("rd_drop", 64'(ip_req_trans), 64'd0);
        complete(4'd0, 32'hDEADBEEF);
        chk("rd_rsp_v", 64'(core_rsp_valid), 64'd1);
        chk("rd_rsp_tag", 64'(core_rsp_tag), 64'd0);
        chk("rd_rsp_data", 64'(core_rsp_rdata), 64'hDEADBEEF);
        tick();
        chk("rsp_pulse", 64'(core_rsp_valid), 64'd0);

        // back-to-back write stream
        do_reset();
        ip_gnt = 1'b1;
        for (int i = 0; i < 6; i++) push_req(1'b1, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i));
        wait_gnts(6);
        ip_gnt = 1'b0;
        if (gnt_cyc.size() >= 6) chk("stream_span", 64'(gnt_cyc[5] - gnt_cyc[0]), 64'd5);
        chk("stream_last_tag", 64'(last_gnt_tag), 64'd5);
        complete(4'd4, 32'h1234_5678);
        chk("wr_rsp_v", 64'(core_rsp_valid), 64'd1);
        chk("wr_rsp_data", 64'(core_rsp_rdata), 64'd0);

        // tag exhaustion
        do_reset();
        ip_gnt = 1'b1;
        for (int i = 0; i < 12; i++) push_req(1'b0, 16'h0200 + 16'(i), 32'd0);
        repeat (3) tick();
        chk("exh_issued", 64'(n_gnt), 64'd8);
        chk("exh_ready", 64'(core_req_ready), 64'd0);
        chk("exh_idle", 64'(ip_req_trans[5]), 64'd0);
        complete(4'd3, 32'h3333_3333);
        wait_gnts(9);
        chk("exh_retag", 64'(last_gnt_tag), 64'd3);
        chk("exh_ready2", 64'(core_req_ready), 64'd1);
        ip_gnt = 1'b0;
        repeat (2) tick();
        chk("exh_rsp_drained", 64'(rsp_q.size()), 64'd0);

        // out-of-order completion
        do_reset();
        ip_gnt = 1'b1;
        for (int i = 0; i < 3; i++) push_req(1'b0, 16'h0300 + 16'(i), 32'd0);
        wait_gnts(3);
        ip_gnt = 1'b0;
        complete(4'd2, 32'hC2C2_0002);
        complete(4'd0, 32'hC0C0_0000);
        complete(4'd1, 32'hC1C1_0001);
        repeat (3) tick();
        chk("ooo_drained", 64'(rsp_q.size()), 64'd0);

        // unexpected completion
        do_reset();
        complete(4'd9, 32'h9999_9999);
        chk("err_rsp", 64'(core_rsp_valid), 64'd0);
        chk("err_set", 64'(err_unexp), 64'd1);
        tick();
        chk("err_sticky", 64'(err_unexp), 64'd1);

        // reset in the middle of an issue
        push_req(1'b0, 16'h0400, 32'd0);
        wait_issue();
        chk("mid_issue", 64'(ip_req_trans[5]), 64'd1);
        do_reset();
        repeat (3) tick();
        chk("mid_dropped", 64'(ip_req_trans), 64'd0);
        complete(4'd0, 32'h0BAD_0BAD);
        chk("mid_err", 64'(err_unexp), 64'd1);
        chk("mid_no_rsp", 64'(core_rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
